// File: rtl/u_xmit_sched_if.sv
// Signal bundle between the transmit scheduler and its requesters and UART transmitter.
// The master side is the scheduler. The slave side is the environment around it.
interface u_xmit_sched_if;
    logic        enable;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic        xmit_h;
    logic [7:0]  xmit_data;
    logic        xmit_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err;
    logic [2:0]  state_dbg;

    modport master (
        input  enable, req, req_data, xmit_done,
        output req_ack, xmit_h, xmit_data, grant_id, busy, err, state_dbg
    );

    modport slave (
        output enable, req, req_data, xmit_done,
        input  req_ack, xmit_h, xmit_data, grant_id, busy, err, state_dbg
    );
endinterface

// File: rtl/u_xmit_sched.sv
// Round-robin scheduler feeding single bytes from four requesters to a UART transmitter.
// It applies a start timeout and inserts a fixed idle gap between frames.
module u_xmit_sched #(
    parameter int GAP_CYCLES = 16,
    parameter int START_TMO  = 4
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    u_xmit_sched_if.master bus
);
    localparam int CNT_MAX = (GAP_CYCLES > START_TMO) ? GAP_CYCLES : START_TMO;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] TMO_LAST = CW'((START_TMO > 1) ? START_TMO - 1 : 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     grant_q, grant_d;
    logic [1:0]     last_q, last_d;
    logic [7:0]     data_q, data_d;
    logic [3:0]     ack_q, ack_d;
    logic           err_q, err_d;

    logic           pick_valid;
    logic [1:0]     pick_idx;
    logic [1:0]     cand;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

    // Walk from the requester furthest from last_q down to the nearest one.
    // The last hit wins, so the search effectively starts at last_q+1.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            cand = last_q + 2'(i);
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        ack_d   = 4'b0000;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && bus.xmit_done && pick_valid) begin
                    state_d = ISSUE;
                    grant_d = pick_idx;
                    data_d  = bus.req_data[{pick_idx, 3'b000} +: 8];
                end
            end
            ISSUE: begin
                state_d = WAIT_LOW;
                cnt_d   = '0;
            end
            WAIT_LOW: begin
                if (!bus.xmit_done) begin
                    state_d = WAIT_HIGH;
                end else if (cnt_q >= TMO_LAST) begin
                    // Transmitter never started: drop the frame without touching last_q.
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            WAIT_HIGH: begin
                if (bus.xmit_done) begin
                    ack_d   = 4'b0001 << grant_q;
                    last_d  = grant_q;
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 2'd0;
            last_q  <= 2'd3;
            data_q  <= 8'h00;
            ack_q   <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.xmit_h    = (state_q == ISSUE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.xmit_data = data_q;
    assign bus.grant_id  = grant_q;
    assign bus.req_ack   = ack_q;
    assign bus.err       = err_q;
    assign bus.state_dbg = state_q;
endmodule

// File: doc/u_xmit_sched.md
U_XMIT_SCHED -- requirements
Module: u_xmit_sched

Interface
REQ-001 Parameter GAP_CYCLES, default 16: idle cycles inserted between consecutive frames.
REQ-002 Parameter START_TMO, default 4: maximum cycles allowed for xmit_done to fall after the xmit_h pulse.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port sys_clk, in, 1: the block clock; all state changes on its rising edge.
REQ-005 Port sys_rst, in, 1: asynchronous active-high reset.
REQ-006 Port enable, in, 1: when 0, no new grant is issued; a frame already in progress completes.
REQ-007 Port req, in, 4: per-requester level request, held until the matching ack.
REQ-008 Port req_data, in, 32: byte for requester i in bits [8i+7:8i].
REQ-009 Port req_ack, out, 4: one-cycle pulse on bit i when requester i's frame completes.
REQ-010 Port xmit_h, out, 1: one-cycle start pulse to the UART transmitter.
REQ-011 Port xmit_data, out, 8: byte presented to the transmitter.
REQ-012 Port xmit_done, in, 1: transmitter done/idle level; high when the transmitter is idle.
REQ-013 Port grant_id, out, 2: index of the current or last granted requester.
REQ-014 Port busy, out, 1: high in every state except IDLE.
REQ-015 Port err, out, 1: one-cycle pulse on start timeout.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH and GAP.
REQ-017 In IDLE, when enable=1, xmit_done=1 and any req bit is set, the block SHALL select one requester and go to ISSUE on the next edge.
  - Selection is round-robin, searching from (last_grant+1) mod 4 upward.
  - grant_id and an internal data register are loaded with that requester's index and req_data byte at this edge.
REQ-018 In ISSUE, xmit_h SHALL be 1 for exactly one cycle, with xmit_data equal to the captured byte; the next state is WAIT_LOW.
REQ-019 xmit_data SHALL hold the captured byte from ISSUE until the FSM leaves WAIT_HIGH; in IDLE it holds the last value.
REQ-020 In WAIT_LOW, a counter SHALL count cycles, and the FSM SHALL go to WAIT_HIGH on the first cycle xmit_done=0.
REQ-021 If xmit_done is still 1 after START_TMO cycles in WAIT_LOW, the block SHALL pulse err for one cycle, issue no ack, leave last_grant unchanged, and go to IDLE.
REQ-022 In WAIT_HIGH, on xmit_done=1 the block SHALL pulse req_ack[grant_id] for one cycle (registered; the pulse is visible in the first GAP cycle), set last_grant=grant_id, and go to GAP.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE; if GAP_CYCLES=0, GAP lasts 1 cycle.
REQ-024 Latency from req sampled in IDLE to xmit_h high SHALL be 1 cycle.
REQ-025 Deasserting req after the grant SHALL NOT abort the frame; the ack is still issued.
REQ-026 Deasserting req before the grant SHALL produce no grant and no ack.
REQ-027 Changing req_data after the grant SHALL NOT affect xmit_data.
REQ-028 A requester whose req is still 1 in the cycle after its ack SHALL be treated as a new request; under contention it is served only after the other requesters in round-robin order.
REQ-029 Setting enable=0 mid-frame SHALL NOT affect ISSUE, WAIT_LOW, WAIT_HIGH or GAP; it only blocks the IDLE-to-ISSUE transition.
REQ-030 At most one req_ack bit SHALL be set in any cycle, and xmit_h SHALL never be asserted outside ISSUE.
REQ-031 All counters SHALL be wide enough for max(GAP_CYCLES, START_TMO) and SHALL saturate rather than wrap.

Reset
REQ-032 Asserting sys_rst SHALL immediately force the following, regardless of state:
  - state = IDLE
  - xmit_h = 0, req_ack = 0, err = 0, busy = 0
  - xmit_data = 8'h00, grant_id = 0
  - last_grant = 3, so the first search starts at requester 0
  - all counters = 0
REQ-033 Reset asserted mid-frame SHALL drop the frame without an ack, and after release the block SHALL restart arbitration from requester 0.

Verification
REQ-034 Single request: req=4'b0100, byte 2 = 8'hA5, xmit_done from a real transmitter model.
  - xmit_h pulses 1 cycle after req.
  - xmit_data = 8'hA5 for the whole frame.
  - req_ack=4'b0100 for 1 cycle after xmit_done rises.
  - busy then stays high for GAP_CYCLES more cycles.
REQ-035 Round-robin: req=4'b1111 held continuously -> grants in order 0,1,2,3,0, with one ack each and a GAP between every frame.
REQ-036 Start timeout: xmit_done tied to 1 -> err pulses START_TMO+1 cycles after xmit_h, no ack, and the same requester is regranted next.
REQ-037 Data stability: after the grant, change req_data to 8'h00 and drop req -> the frame carries the original byte and the ack still fires.
REQ-038 Enable gating: enable=0 with req=4'b0001 -> no xmit_h. Then drop enable mid-frame -> the frame completes and no new grant is issued until enable returns to 1.
REQ-039 Reset mid-frame: assert sys_rst during WAIT_HIGH -> all outputs go to reset values asynchronously, and after release with req=4'b1010, requester 1 is granted first.
